ps_flops_ex_wb_pipe: RTL and testbench
======================================

# ps_flops_ex_wb_pipe

Parametrised EX→WB pipeline register for the ALU writeback path: carries wavefront ID, instruction PC, VGPR/SGPR destination addresses, instruction-done and VGPR/SGPR/VCC write enables from the ALU execute stage to the writeback arbiter. It generalises the single-flop EX/WB stage to DEPTH stages with a valid/ready handshake, bubble collapsing and per-wavefront flush. It sits between the ALU execute datapath and the writeback/register-file arbiter.

## Interface
- DEPTH, 2, number of pipeline stages (1..4)
- WFID_W, 6, wavefront ID width
- PC_W, 32, instruction PC width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset (rst=0 resets on the next rising clk edge)
- in_valid  in  1  EX payload valid
- in_ready  out  1  pipe accepts payload this cycle
- in_wfid / in_instr_pc  in  WFID_W / PC_W  wavefront ID, PC
- in_vgpr_dest_addr / in_sgpr_dest_addr  in  10 / 9  destination addresses
- in_instr_done, in_vgpr_wr_en, in_sgpr_wr_en, in_vcc_wr_en  in  1 each  control bits
- flush_en  in  1  kill all in-flight entries of flush_wfid
- flush_wfid  in  WFID_W  wavefront to kill
- out_ready  in  1  WB arbiter accepts head entry
- out_valid  out  1  head entry valid
- out_wfid, out_instr_pc, out_vgpr_dest_addr, out_sgpr_dest_addr  out  as inputs  head payload
- out_instr_done, out_vgpr_dest_wr_en, out_sgpr_dest_wr_en, out_vcc_wr_en  out  1 each  head control bits, forced 0 when out_valid=0
- occupancy  out  $clog2(DEPTH+1)  number of valid stages
- (EX_WB_PENDING_QUERY_EN only) query_vgpr_addr in 10, query_hit out 1

## Operation
- Stages S0 (entry) .. S[DEPTH-1] (head); each holds valid bit + payload.
- Head drains when out_valid & out_ready. Stage i advances into i+1 when i+1 is empty or draining/advancing the same cycle (bubble collapse; no gaps held behind a stall).
- in_ready = rst & (~S0.valid | S0 advancing). Transfer on in_valid & in_ready.
- Flush: when flush_en, every stage whose wfid == flush_wfid has valid cleared at the next edge (its payload is not moved). An input transfer with in_wfid == flush_wfid in a flush cycle is dropped. Head entry handshaking in the flush cycle counts as delivered (outputs are registered; flush acts next cycle).
- Payload registers hold when not loaded; control outputs gated by out_valid.
- occupancy = popcount of stage valid bits, registered view.

## Timing
- Reset: all valid=0, payload=0, out_valid=0, all out_* =0, occupancy=0, in_ready=0 while rst=0, 1 the cycle after release.
- Latency with out_ready held 1: input at edge t appears at outputs after DEPTH edges; throughput 1/cycle.
- Full (all DEPTH valid, out_ready=0): in_ready=0; nothing moves. Full with out_ready=1: in_ready=1, simultaneous enqueue+dequeue, occupancy unchanged.
- Reset asserted mid-operation discards all entries regardless of handshakes that cycle.
- Flush + drain of same entry: delivered once; flush + enqueue of matching wfid: dropped, in_ready still 1 (accept-and-discard).

## Configuration
- EX_WB_PENDING_QUERY_EN defined: adds query_vgpr_addr/query_hit; query_hit (combinational) = OR over valid stages with vgpr_dest_wr_en and vgpr_dest_addr == query_vgpr_addr, used by issue for RAW hazard check. Excludes input port.
- Undefined: ports absent, no compare logic.

## Structure
- Shared package/include: payload field widths (VGPR addr 10, SGPR addr 9), payload struct/bit-layout constants, DEPTH bounds.
- One sub-module: ps_ex_wb_stage (one valid+payload register with load/clear control), instantiated DEPTH times.

## Test plan
- Reset: rst=0 for 3 cycles with in_valid=1 → out_valid=0, occupancy=0, all outputs 0; in_ready=1 cycle after release.
- Streaming, DEPTH=2: enqueue PCs 0x100,0x104,0x108 back-to-back, out_ready=1 → same order at outputs, first 2 cycles after entry, one per cycle.
- Backpressure: out_ready=0, enqueue 3 entries DEPTH=2 → 2 accepted, in_ready=0, occupancy=2; release → drain in order, no loss/duplication.
- Flush: stages hold wfid 3,5; flush_en with flush_wfid=3 and in_wfid=3 enqueuing → only wfid 5 emerges, occupancy drops to 1.
- Bubble collapse: DEPTH=4, single entry, out_ready=0 → reaches head after 4 cycles; second entry stacks behind it immediately.
- With EX_WB_PENDING_QUERY_EN: in-flight vgpr_dest_addr=0x2A wr_en=1 → query 0x2A hit=1, 0x2B hit=0; after drain hit=0.

Source files
------------

// File: rtl/ps_flops_ex_wb_pipe_pkg.sv
// Shared widths, payload bit layout and depth bounds for the EX->WB pipeline register.
package ps_flops_ex_wb_pipe_pkg;

  localparam int VGPR_ADDR_W = 10;
  localparam int SGPR_ADDR_W = 9;
  localparam int DEPTH_MIN   = 1;
  localparam int DEPTH_MAX   = 4;

  typedef struct packed {
    logic instr_done;
    logic vgpr_wr_en;
    logic sgpr_wr_en;
    logic vcc_wr_en;
  } ex_wb_ctrl_t;

  // Flat payload layout, LSB first: ctrl | sgpr addr | vgpr addr | pc | wfid.
  localparam int CTRL_W         = $bits(ex_wb_ctrl_t);
  localparam int CTRL_LSB       = 0;
  localparam int VGPR_WR_EN_BIT = CTRL_LSB + 2;
  localparam int SGPR_LSB       = CTRL_LSB + CTRL_W;
  localparam int VGPR_LSB       = SGPR_LSB + SGPR_ADDR_W;
  localparam int PC_LSB         = VGPR_LSB + VGPR_ADDR_W;

  function automatic int payload_w(input int wfid_w, input int pc_w);
    return PC_LSB + pc_w + wfid_w;
  endfunction

endpackage

// File: rtl/ps_ex_wb_stage.sv
// One pipeline slot: valid bit plus payload. Load wins over clear; payload holds unless loaded.
module ps_ex_wb_stage
  import ps_flops_ex_wb_pipe_pkg::*;
#(
  parameter int W = payload_w(6, 32)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ps_flops_ex_wb_pipe.sv
// DEPTH-stage EX->WB register with bubble collapse and per-wavefront flush.
// Optional EX_WB_PENDING_QUERY_EN adds a pending-VGPR-write query port for RAW checks.
module ps_flops_ex_wb_pipe
  import ps_flops_ex_wb_pipe_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int WFID_W = 6,
  parameter int PC_W   = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WFID_W-1:0]            in_wfid,
  input  logic [PC_W-1:0]              in_instr_pc,
  input  logic [VGPR_ADDR_W-1:0]       in_vgpr_dest_addr,
  input  logic [SGPR_ADDR_W-1:0]       in_sgpr_dest_addr,
  input  logic                         in_instr_done,
  input  logic                         in_vgpr_wr_en,
  input  logic                         in_sgpr_wr_en,
  input  logic                         in_vcc_wr_en,
  input  logic                         flush_en,
  input  logic [WFID_W-1:0]            flush_wfid,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [WFID_W-1:0]            out_wfid,
  output logic [PC_W-1:0]              out_instr_pc,
  output logic [VGPR_ADDR_W-1:0]       out_vgpr_dest_addr,
  output logic [SGPR_ADDR_W-1:0]       out_sgpr_dest_addr,
  output logic                         out_instr_done,
  output logic                         out_vgpr_dest_wr_en,
  output logic                         out_sgpr_dest_wr_en,
  output logic                         out_vcc_wr_en,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef EX_WB_PENDING_QUERY_EN
  ,
  input  logic [VGPR_ADDR_W-1:0]       query_vgpr_addr,
  output logic                         query_hit
`endif
);

  localparam int PW       = payload_w(WFID_W, PC_W);
  localparam int WFID_LSB = PC_LSB + PC_W;
  localparam int OCC_W    = $clog2(DEPTH + 1);

  logic [PW-1:0]    in_payload;
  logic [PW-1:0]    stage_d [DEPTH];
  logic [PW-1:0]    stage_q [DEPTH];
  logic [DEPTH-1:0] stage_valid;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] kill;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] clear;
  logic             in_fire;
  logic             in_kill;
  logic [PW-1:0]    head;
  ex_wb_ctrl_t      head_ctrl;

  assign in_payload = {in_wfid, in_instr_pc, in_vgpr_dest_addr, in_sgpr_dest_addr,
                       in_instr_done, in_vgpr_wr_en, in_sgpr_wr_en, in_vcc_wr_en};

  // A stage moves up when some stage above it has a gap, or when the head drains
  // (which frees the whole full run above it). Flush does not affect movement.
  always_comb begin
    logic full_above;
    adv        = '0;
    full_above = 1'b1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      adv[i]     = stage_valid[i] & (~full_above | out_ready);
      full_above = full_above & stage_valid[i];
    end
  end

  always_comb begin
    kill = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill[i] = flush_en & stage_valid[i] & (stage_q[i][WFID_LSB +: WFID_W] == flush_wfid);
    end
  end

  // Handshake: a payload transfers on the rising edge where in_valid & in_ready,
  // and the head is consumed on the edge where out_valid & out_ready. in_ready
  // never depends on in_valid; out_valid never depends on out_ready.
  assign in_ready = rst & (~stage_valid[0] | adv[0]);
  assign in_fire  = in_valid & in_ready;
  assign in_kill  = flush_en & (in_wfid == flush_wfid);

  // An entry killed while moving lands as an empty slot.
  always_comb begin
    load     = '0;
    clear    = '0;
    load[0]  = in_fire & ~in_kill;
    clear[0] = (in_fire & in_kill) | adv[0] | kill[0];
    for (int i = 1; i < DEPTH; i++) begin
      load[i]  = adv[i-1] & ~kill[i-1];
      clear[i] = (adv[i-1] & kill[i-1]) | adv[i] | kill[i];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_entry
      assign stage_d[g] = in_payload;
    end else begin : g_chain
      assign stage_d[g] = stage_q[g-1];
    end

    ps_ex_wb_stage #(
      .W(PW)
    ) u_stage (
      .clk  (clk),
      .rst  (rst),
      .load (load[g]),
      .clear(clear[g]),
      .d    (stage_d[g]),
      .valid(stage_valid[g]),
      .q    (stage_q[g])
    );
  end

  assign head      = stage_q[DEPTH-1];
  assign head_ctrl = head[CTRL_LSB +: CTRL_W];

  assign out_valid           = stage_valid[DEPTH-1];
  assign out_wfid            = head[WFID_LSB +: WFID_W];
  assign out_instr_pc        = head[PC_LSB +: PC_W];
  assign out_vgpr_dest_addr  = head[VGPR_LSB +: VGPR_ADDR_W];
  assign out_sgpr_dest_addr  = head[SGPR_LSB +: SGPR_ADDR_W];
  assign out_instr_done      = out_valid & head_ctrl.instr_done;
  assign out_vgpr_dest_wr_en = out_valid & head_ctrl.vgpr_wr_en;
  assign out_sgpr_dest_wr_en = out_valid & head_ctrl.sgpr_wr_en;
  assign out_vcc_wr_en       = out_valid & head_ctrl.vcc_wr_en;

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(stage_valid[i]);
    end
  end

`ifdef EX_WB_PENDING_QUERY_EN
  // Only in-flight entries count; the input port is deliberately excluded.
  always_comb begin
    query_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (stage_valid[i] && stage_q[i][VGPR_WR_EN_BIT] &&
          (stage_q[i][VGPR_LSB +: VGPR_ADDR_W] == query_vgpr_addr)) begin
        query_hit = 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ps_flops_ex_wb_pipe.sv
// Bench for ps_flops_ex_wb_pipe: DEPTH=2 and DEPTH=4 instances on shared stimulus, checked against a slot-array model.
module tb_ps_flops_ex_wb_pipe;

  typedef struct packed {
    logic [5:0]  wfid;
    logic [31:0] pc;
    logic [9:0]  vgpr;
    logic [8:0]  sgpr;
    logic [3:0]  ctrl;
  } ent_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        in_valid;
  logic [5:0]  in_wfid;
  logic [31:0] in_instr_pc;
  logic [9:0]  in_vgpr_dest_addr;
  logic [8:0]  in_sgpr_dest_addr;
  logic        in_instr_done, in_vgpr_wr_en, in_sgpr_wr_en, in_vcc_wr_en;
  logic        flush_en;
  logic [5:0]  flush_wfid;
  logic        out_ready;
  logic [9:0]  query_vgpr_addr;

  logic        d2_in_ready, d2_out_valid, d2_done, d2_vwr, d2_swr, d2_vcc, d2_hit;
  logic [5:0]  d2_wfid;
  logic [31:0] d2_pc;
  logic [9:0]  d2_vgpr;
  logic [8:0]  d2_sgpr;
  logic [1:0]  d2_occ;

  logic        d4_in_ready, d4_out_valid, d4_done, d4_vwr, d4_swr, d4_vcc, d4_hit;
  logic [5:0]  d4_wfid;
  logic [31:0] d4_pc;
  logic [9:0]  d4_vgpr;
  logic [8:0]  d4_sgpr;
  logic [2:0]  d4_occ;

  ps_flops_ex_wb_pipe #(.DEPTH(2), .WFID_W(6), .PC_W(32)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d2_in_ready),
    .in_wfid(in_wfid), .in_instr_pc(in_instr_pc),
    .in_vgpr_dest_addr(in_vgpr_dest_addr), .in_sgpr_dest_addr(in_sgpr_dest_addr),
    .in_instr_done(in_instr_done), .in_vgpr_wr_en(in_vgpr_wr_en),
    .in_sgpr_wr_en(in_sgpr_wr_en), .in_vcc_wr_en(in_vcc_wr_en),
    .flush_en(flush_en), .flush_wfid(flush_wfid), .out_ready(out_ready),
    .out_valid(d2_out_valid), .out_wfid(d2_wfid), .out_instr_pc(d2_pc),
    .out_vgpr_dest_addr(d2_vgpr), .out_sgpr_dest_addr(d2_sgpr),
    .out_instr_done(d2_done), .out_vgpr_dest_wr_en(d2_vwr),
    .out_sgpr_dest_wr_en(d2_swr), .out_vcc_wr_en(d2_vcc), .occupancy(d2_occ)
`ifdef EX_WB_PENDING_QUERY_EN
    , .query_vgpr_addr(query_vgpr_addr), .query_hit(d2_hit)
`endif
  );

  ps_flops_ex_wb_pipe #(.DEPTH(4), .WFID_W(6), .PC_W(32)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d4_in_ready),
    .in_wfid(in_wfid), .in_instr_pc(in_instr_pc),
    .in_vgpr_dest_addr(in_vgpr_dest_addr), .in_sgpr_dest_addr(in_sgpr_dest_addr),
    .in_instr_done(in_instr_done), .in_vgpr_wr_en(in_vgpr_wr_en),
    .in_sgpr_wr_en(in_sgpr_wr_en), .in_vcc_wr_en(in_vcc_wr_en),
    .flush_en(flush_en), .flush_wfid(flush_wfid), .out_ready(out_ready),
    .out_valid(d4_out_valid), .out_wfid(d4_wfid), .out_instr_pc(d4_pc),
    .out_vgpr_dest_addr(d4_vgpr), .out_sgpr_dest_addr(d4_sgpr),
    .out_instr_done(d4_done), .out_vgpr_dest_wr_en(d4_vwr),
    .out_sgpr_dest_wr_en(d4_swr), .out_vcc_wr_en(d4_vcc), .occupancy(d4_occ)
`ifdef EX_WB_PENDING_QUERY_EN
    , .query_vgpr_addr(query_vgpr_addr), .query_hit(d4_hit)
`endif
  );

`ifndef EX_WB_PENDING_QUERY_EN
  assign d2_hit = 1'b0;
  assign d4_hit = 1'b0;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;
  logic chk_en = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else pass_cnt++;
  endtask

  // behavioural model: slot k holds a list of DEPTH positions, head at the top
  function automatic int dep(input int k);
    return (k == 0) ? 2 : 4;
  endfunction

  ent_t m_e [2][4];
  logic m_v [2][4];
  ent_t nx_e [2][4];
  logic nx_v [2][4];
  int   m_occ [2];
  ent_t in_ent;

  assign in_ent = {in_wfid, in_instr_pc, in_vgpr_dest_addr, in_sgpr_dest_addr,
                   in_instr_done, in_vgpr_wr_en, in_sgpr_wr_en, in_vcc_wr_en};

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      m_occ[k] = 0;
      for (int i = 0; i < 4; i++) m_occ[k] = m_occ[k] + (m_v[k][i] ? 1 : 0);
    end
  end

  function automatic logic exp_rdy(input int occ, input int d);
    return rst && ((occ < d) || out_ready);
  endfunction

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        nx_e[k][i] = m_e[k][i];
        nx_v[k][i] = m_v[k][i];
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        for (int i = 0; i < 4; i++) nx_v[k][i] = 1'b0;
      end else begin
        if (out_ready && nx_v[k][dep(k)-1]) nx_v[k][dep(k)-1] = 1'b0;
        for (int i = dep(k) - 2; i >= 0; i--) begin
          if (nx_v[k][i] && !nx_v[k][i+1]) begin
            nx_e[k][i+1] = nx_e[k][i];
            nx_v[k][i+1] = 1'b1;
            nx_v[k][i]   = 1'b0;
          end
        end
        if (flush_en) begin
          for (int i = 0; i < dep(k); i++)
            if (nx_v[k][i] && nx_e[k][i].wfid == flush_wfid) nx_v[k][i] = 1'b0;
        end
        if (in_valid && exp_rdy(m_occ[k], dep(k)) && !(flush_en && in_wfid == flush_wfid)) begin
          nx_v[k][0] = 1'b1;
          nx_e[k][0] = in_ent;
        end
      end
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        m_e[k][i] <= nx_e[k][i];
        m_v[k][i] <= nx_v[k][i];
      end
    end
  end

  task automatic cmp_dut(input int k, input logic rdy, input logic ov, input logic [2:0] occ,
                         input logic [5:0] wf, input logic [31:0] pc, input logic [9:0] vg,
                         input logic [8:0] sg, input logic [3:0] ctrl, input logic hit);
    int   h;
    ent_t e;
    logic ehit;
    h = dep(k) - 1;
    e = m_e[k][h];
    check($sformatf("d%0d in_ready", dep(k)), 64'(rdy), 64'(exp_rdy(m_occ[k], dep(k))));
    check($sformatf("d%0d out_valid", dep(k)), 64'(ov), 64'(m_v[k][h]));
    check($sformatf("d%0d occupancy", dep(k)), 64'(occ), 64'(m_occ[k]));
    check($sformatf("d%0d ctrl", dep(k)), 64'(ctrl), m_v[k][h] ? 64'(e.ctrl) : 64'd0);
    if (m_v[k][h]) begin
      check($sformatf("d%0d payload", dep(k)), {7'd0, wf, pc, vg, sg}, {7'd0, e.wfid, e.pc, e.vgpr, e.sgpr});
    end
    ehit = 1'b0;
    for (int i = 0; i < dep(k); i++)
      if (m_v[k][i] && m_e[k][i].ctrl[2] && m_e[k][i].vgpr == query_vgpr_addr) ehit = 1'b1;
`ifdef EX_WB_PENDING_QUERY_EN
    check($sformatf("d%0d query_hit", dep(k)), 64'(hit), 64'(ehit));
`endif
  endtask

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_dut(0, d2_in_ready, d2_out_valid, {1'b0, d2_occ}, d2_wfid, d2_pc, d2_vgpr, d2_sgpr,
              {d2_done, d2_vwr, d2_swr, d2_vcc}, d2_hit);
      cmp_dut(1, d4_in_ready, d4_out_valid, d4_occ, d4_wfid, d4_pc, d4_vgpr, d4_sgpr,
              {d4_done, d4_vwr, d4_swr, d4_vcc}, d4_hit);
    end
  end

  // delivery monitor for the DEPTH=2 instance
  always @(negedge clk) begin
    if (chk_en && rst && d2_out_valid && out_ready) got_q.push_back(d2_pc);
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [5:0] w, input logic [31:0] pc);
    in_valid          = v;
    in_wfid           = w;
    in_instr_pc       = pc;
    in_vgpr_dest_addr = 10'h28 + 10'($urandom_range(0, 7));
    in_sgpr_dest_addr = 9'($urandom_range(0, 511));
    in_instr_done     = 1'($urandom_range(0, 1));
    in_vgpr_wr_en     = 1'($urandom_range(0, 1));
    in_sgpr_wr_en     = 1'($urandom_range(0, 1));
    in_vcc_wr_en      = 1'($urandom_range(0, 1));
  endtask

  task automatic check_got(input string name);
    check({name, " count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s pc[%0d]", name, i), 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  initial begin
    rst = 1'b0;
    flush_en = 1'b0;
    flush_wfid = '0;
    out_ready = 1'b1;
    query_vgpr_addr = 10'h2A;
    set_in(1'b1, 6'd9, 32'hDEAD_0000);

    // reset held 3 cycles with in_valid asserted
    tick();
    chk_en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("reset out_valid", 64'(d2_out_valid), 64'd0);
    check("reset occupancy", 64'(d2_occ), 64'd0);
    check("reset in_ready", 64'(d2_in_ready), 64'd0);
    check("reset out pc", 64'(d2_pc), 64'd0);
    check("reset out wfid", 64'(d2_wfid), 64'd0);
    check("reset d4 occupancy", 64'(d4_occ), 64'd0);
    tick();
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("in_ready after release", 64'(d2_in_ready), 64'd1);

    // streaming
    tick();
    got_q.delete();
    set_in(1'b1, 6'd1, 32'h100);
    tick();
    set_in(1'b1, 6'd1, 32'h104);
    tick();
    set_in(1'b1, 6'd1, 32'h108);
    @(negedge clk);
    check("stream first head valid", 64'(d2_out_valid), 64'd1);
    check("stream first head pc", 64'(d2_pc), 64'h100);
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    exp_q = '{32'h100, 32'h104, 32'h108};
    check_got("stream");

    // backpressure
    got_q.delete();
    out_ready = 1'b0;
    set_in(1'b1, 6'd2, 32'h200);
    tick();
    set_in(1'b1, 6'd2, 32'h204);
    tick();
    set_in(1'b1, 6'd2, 32'h208);
    repeat (3) tick();
    @(negedge clk);
    check("bp in_ready", 64'(d2_in_ready), 64'd0);
    check("bp occupancy", 64'(d2_occ), 64'd2);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    exp_q = '{32'h200, 32'h204};
    check_got("bp");

    // flush of wfid 3 with a matching enqueue attempt
    got_q.delete();
    out_ready = 1'b0;
    set_in(1'b1, 6'd3, 32'h300);
    tick();
    set_in(1'b1, 6'd5, 32'h304);
    tick();
    set_in(1'b1, 6'd3, 32'h308);
    flush_en = 1'b1;
    flush_wfid = 6'd3;
    tick();
    flush_en = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush occupancy", 64'(d2_occ), 64'd1);
    tick();
    out_ready = 1'b1;
    repeat (5) tick();
    exp_q = '{32'h304};
    check_got("flush");

    // accept-and-discard into an empty pipe
    set_in(1'b1, 6'd7, 32'h500);
    flush_en = 1'b1;
    flush_wfid = 6'd7;
    @(negedge clk);
    check("discard in_ready", 64'(d2_in_ready), 64'd1);
    tick();
    flush_en = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("discard occupancy d2", 64'(d2_occ), 64'd0);
    check("discard occupancy d4", 64'(d4_occ), 64'd0);

    // bubble collapse on DEPTH=4
    tick();
    out_ready = 1'b0;
    set_in(1'b1, 6'd1, 32'h400);
    tick();
    set_in(1'b1, 6'd1, 32'h404);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("bubble head after 2", 64'(d4_out_valid), 64'd0);
    @(negedge clk);
    check("bubble head after 3", 64'(d4_out_valid), 64'd0);
    @(negedge clk);
    check("bubble head after 4", 64'(d4_out_valid), 64'd1);
    check("bubble head pc", 64'(d4_pc), 64'h400);
    check("bubble occupancy", 64'(d4_occ), 64'd2);
    tick();
    out_ready = 1'b1;
    repeat (6) tick();

`ifdef EX_WB_PENDING_QUERY_EN
    out_ready = 1'b0;
    set_in(1'b1, 6'd2, 32'h600);
    in_vgpr_dest_addr = 10'h2A;
    in_vgpr_wr_en = 1'b1;
    tick();
    in_valid = 1'b0;
    query_vgpr_addr = 10'h2A;
    @(negedge clk);
    check("query hit 0x2A", 64'(d2_hit), 64'd1);
    tick();
    query_vgpr_addr = 10'h2B;
    @(negedge clk);
    check("query miss 0x2B", 64'(d2_hit), 64'd0);
    tick();
    out_ready = 1'b1;
    repeat (6) tick();
    query_vgpr_addr = 10'h2A;
    @(negedge clk);
    check("query after drain", 64'(d2_hit), 64'd0);
    tick();
`endif

    // randomized traffic with flushes and occasional mid-operation reset
    for (int n = 0; n < 2000; n++) begin
      tick();
      rst        = ($urandom_range(0, 99) != 0);
      set_in(1'($urandom_range(0, 1)), 6'($urandom_range(0, 3)), $urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      flush_en   = ($urandom_range(0, 7) == 0);
      flush_wfid = 6'($urandom_range(0, 3));
      query_vgpr_addr = 10'h28 + 10'($urandom_range(0, 7));
    end

    tick();
    rst = 1'b1;
    in_valid = 1'b0;
    flush_en = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
